// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer: FSM encoding,
// operation select codes and default iteration counts.
package muldiv_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LOAD  = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_WRITE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   localparam int ITER_MULT_DEF = 32;
   localparam int ITER_DIV_DEF  = 32;

endpackage

// File: rtl/hi_lo_reg.sv
// Architectural HI/LO register pair with a shared write enable.
module hi_lo_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             we_i,
   input  logic [WIDTH-1:0] hi_i,
   input  logic [WIDTH-1:0] lo_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   // Capture both words together; otherwise hold indefinitely.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (we_i) begin
         hi_q <= hi_i;
         lo_q <= lo_i;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer for the iterative multiply/divide cores: latches the request,
// pulses the core load, steps it a fixed count, then writes HI/LO.
module muldiv_ctrl
   import muldiv_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int ITER_MULT = ITER_MULT_DEF,
   parameter int ITER_DIV  = ITER_DIV_DEF,
   parameter int CNT_W     = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             op_start,
   input  logic             op_sel,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             core_sel,
   output logic             core_load,
   output logic             core_step,
   output logic [WIDTH-1:0] core_a,
   output logic [WIDTH-1:0] core_b,
   input  logic [WIDTH-1:0] core_hi,
   input  logic [WIDTH-1:0] core_lo,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic             sel_q,   sel_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             dz_q,    dz_d;

   // Next-state, counter and operand-latch decode.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      a_d     = a_q;
      b_d     = b_q;
      dz_d    = dz_q;
      case (state_q)
         ST_IDLE: begin
            if (op_start) begin
               sel_d = op_sel;
               a_d   = op_a;
               b_d   = op_b;
               // A zero divisor never touches the core; report it directly.
               if ((op_sel == OP_DIV) && (op_b == '0)) begin
                  dz_d    = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            cnt_d   = (sel_q == OP_DIV) ? CNT_W'(ITER_DIV) : CNT_W'(ITER_MULT);
            state_d = ST_RUN;
         end
         ST_RUN: begin
            // The step with cnt==1 is the last one, so RUN lasts exactly ITER cycles.
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            dz_d    = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and operand registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         sel_q   <= OP_MULT;
         a_q     <= '0;
         b_q     <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         dz_q    <= dz_d;
      end
   end

   hi_lo_reg #(
      .WIDTH (WIDTH)
   ) u_hi_lo (
      .clk_i   (clk),
      .reset_i (reset),
      .we_i    (state_q == ST_WRITE),
      .hi_i    (core_hi),
      .lo_i    (core_lo),
      .hi_o    (hi),
      .lo_o    (lo)
   );

   // Outputs decode purely from registered state.
   assign core_sel  = sel_q;
   assign core_a    = a_q;
   assign core_b    = b_q;
   assign core_load = (state_q == ST_LOAD);
   assign core_step = (state_q == ST_RUN);
   assign busy      = (state_q == ST_LOAD) || (state_q == ST_RUN) || (state_q == ST_WRITE);
   assign done      = (state_q == ST_DONE);
   assign div_zero  = (state_q == ST_DONE) && dz_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: behavioural core plus a reference model of the
// architectural HI/LO result and the request/response timing.
module tb_muldiv_ctrl;

   localparam int W    = 32;
   localparam int ITER = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          op_start;
   logic          op_sel;
   logic [W-1:0]  op_a, op_b;
   logic          core_sel, core_load, core_step;
   logic [W-1:0]  core_a, core_b, core_hi, core_lo;
   logic          busy, done, div_zero;
   logic [W-1:0]  hi, lo;

   muldiv_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .op_start  (op_start),
      .op_sel    (op_sel),
      .op_a      (op_a),
      .op_b      (op_b),
      .core_sel  (core_sel),
      .core_load (core_load),
      .core_step (core_step),
      .core_a    (core_a),
      .core_b    (core_b),
      .core_hi   (core_hi),
      .core_lo   (core_lo),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .hi        (hi),
      .lo        (lo)
   );

   always #5 clk = ~clk;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   // Global edge counter; cycle k after acceptance is observed at the
   // falling edge where cyc - base == k.
   int cyc  = 0;
   int base = 0;
   always @(posedge clk) cyc = cyc + 1;

   // Behavioural core: result is only correct after exactly ITER steps.
   logic [W-1:0] cm_a = '0, cm_b = '0;
   logic         cm_sel = 1'b0;
   int           cm_steps = 0;
   int           step_cnt = 0;
   always @(posedge clk) begin
      if (core_load) begin
         cm_a = core_a; cm_b = core_b; cm_sel = core_sel; cm_steps = 0;
      end else if (core_step) begin
         cm_steps = cm_steps + 1;
         step_cnt = step_cnt + 1;
      end
   end

   always_comb begin
      longint sa, sb, p;
      logic [W-1:0] rh, rl;
      sa = longint'($signed(cm_a));
      sb = longint'($signed(cm_b));
      if (cm_sel) begin
         rl = (sb == 0) ? '1 : W'(sa / sb);
         rh = (sb == 0) ? cm_a : W'(sa % sb);
      end else begin
         p  = sa * sb;
         rh = p[63:32];
         rl = p[31:0];
      end
      if (cm_steps != ITER) begin
         rh = rh ^ (32'hA5A5_0000 | W'(cm_steps));
         rl = rl ^ 32'h0F0F_0F0F;
      end
      core_hi = rh;
      core_lo = rl;
   end

   // Falling-edge monitor for control strobes.
   int load_cnt = 0, load_rel = -1, busy_cnt = 0, first_busy = -1, done_cnt = 0;
   always @(negedge clk) begin
      if (core_load) begin
         load_cnt = load_cnt + 1;
         load_rel = cyc - base;
      end
      if (busy) begin
         if (busy_cnt == 0) first_busy = cyc - base;
         busy_cnt = busy_cnt + 1;
      end
      if (done) done_cnt = done_cnt + 1;
   end

   // Reference architectural state.
   logic [W-1:0] exp_hi = '0, exp_lo = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic clr_mon();
      load_cnt = 0; load_rel = -1; busy_cnt = 0; first_busy = -1;
      done_cnt = 0; step_cnt = 0;
   endtask

   // Predict the result of one operation from the arithmetic definition.
   task automatic predict(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel);
      longint sa, sb, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sel == 1'b0) begin
         p = sa * sb;
         exp_hi = p[63:32];
         exp_lo = p[31:0];
      end else if (b != 0) begin
         exp_lo = W'(sa / sb);
         exp_hi = W'(sa - (sa / sb) * sb);
      end
   endtask

   // Wait up to a bound for done; returns the relative cycle or -1.
   task automatic wait_done(output int rel);
      rel = -1;
      for (int k = 0; k < 80; k++) begin
         if (done) begin
            rel = cyc - base;
            break;
         end
         @(negedge clk);
      end
   endtask

   // One full request with timing and result checks.
   task automatic do_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sel);
      logic dz;
      int   rel;
      dz = sel && (b == 0);
      @(negedge clk);
      clr_mon();
      base = cyc;
      op_a = a; op_b = b; op_sel = sel; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      op_a = $urandom; op_b = $urandom;
      wait_done(rel);
      predict(a, b, sel);
      chk({nm, ".done_cyc"}, 64'(rel), dz ? 64'd1 : 64'(ITER + 3));
      chk({nm, ".hi"}, 64'(hi), 64'(exp_hi));
      chk({nm, ".lo"}, 64'(lo), 64'(exp_lo));
      chk({nm, ".div_zero"}, 64'(div_zero), 64'(dz));
      chk({nm, ".busy_at_done"}, 64'(busy), 64'd0);
      chk({nm, ".loads"}, 64'(load_cnt), dz ? 64'd0 : 64'd1);
      chk({nm, ".steps"}, 64'(step_cnt), dz ? 64'd0 : 64'(ITER));
      chk({nm, ".busy_cycles"}, 64'(busy_cnt), dz ? 64'd0 : 64'(ITER + 2));
      if (!dz) begin
         chk({nm, ".load_cyc"}, 64'(load_rel), 64'd1);
         chk({nm, ".busy_first"}, 64'(first_busy), 64'd1);
      end
      @(negedge clk);
      chk({nm, ".done_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int rel1, rel2;
      reset = 1'b1; op_start = 1'b0; op_sel = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.done", 64'(done), 64'd0);
      chk("rst.hi", 64'(hi), 64'd0);
      chk("rst.lo", 64'(lo), 64'd0);
      chk("rst.load_step", 64'({core_load, core_step, div_zero}), 64'd0);
      reset = 1'b0;

      do_op("mult7x-3", 32'd7, 32'hFFFF_FFFD, 1'b0);
      chk("mult7x-3.hi_const", 64'(hi), 64'hFFFF_FFFF);
      chk("mult7x-3.lo_const", 64'(lo), 64'hFFFF_FFEB);

      do_op("div100_7", 32'd100, 32'd7, 1'b1);
      chk("div100_7.q", 64'(lo), 64'd14);
      chk("div100_7.r", 64'(hi), 64'd2);

      do_op("div_setup", 32'h0ACF_1234, 32'h0000_2000, 1'b1);
      chk("div_setup.hi", 64'(hi), 64'h1234);
      chk("div_setup.lo", 64'(lo), 64'h5678);
      do_op("div0", 32'd5, 32'd0, 1'b1);
      chk("div0.hi_kept", 64'(hi), 64'h1234);
      chk("div0.lo_kept", 64'(lo), 64'h5678);

      // Held request: mid-op operand change ignored, retry accepted after DONE.
      @(negedge clk);
      clr_mon();
      base = cyc;
      op_a = 32'd5; op_b = 32'd6; op_sel = 1'b0; op_start = 1'b1;
      @(negedge clk);
      op_a = 32'd9;
      wait_done(rel1);
      chk("b2b.first_cyc", 64'(rel1), 64'(ITER + 3));
      chk("b2b.first_lo", 64'(lo), 64'd30);
      @(negedge clk);
      @(negedge clk);
      op_start = 1'b0;
      wait_done(rel2);
      chk("b2b.second_cyc", 64'(rel2), 64'(ITER + 3 + 1 + ITER + 3));
      chk("b2b.second_lo", 64'(lo), 64'd54);
      chk("b2b.steps", 64'(step_cnt), 64'(2 * ITER));
      exp_hi = '0; exp_lo = 32'd54;

      // Reset in the middle of RUN.
      @(negedge clk);
      clr_mon();
      base = cyc;
      op_a = 32'd11; op_b = 32'd13; op_sel = 1'b0; op_start = 1'b1;
      @(negedge clk);
      op_start = 1'b0;
      repeat (9) @(negedge clk);
      chk("rstrun.in_run", 64'(core_step), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("rstrun.busy", 64'(busy), 64'd0);
      chk("rstrun.step", 64'(core_step), 64'd0);
      chk("rstrun.hi", 64'(hi), 64'd0);
      chk("rstrun.lo", 64'(lo), 64'd0);
      repeat (40) @(negedge clk);
      chk("rstrun.no_done", 64'(done_cnt), 64'd0);
      exp_hi = '0; exp_lo = '0;
      do_op("mult3x4", 32'd3, 32'd4, 1'b0);
      chk("mult3x4.lo", 64'(lo), 64'd12);
      chk("mult3x4.hi", 64'(hi), 64'd0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] ra, rb;
         logic         rs;
         ra = $urandom;
         rb = $urandom;
         rs = 1'($urandom_range(0, 1));
         if (rs && ($urandom_range(0, 3) == 0)) rb = '0;
         if (rs && ($urandom_range(0, 2) == 0)) rb = W'($urandom_range(1, 50));
         do_op($sformatf("rnd%0d", i), ra, rb, rs);
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
